// File: rtl/matmul_stream_pkg.sv
// Shared types and sizing helpers for the matmul operand streamer.
// Optional feature macro: MATMUL_STREAM_STALL_CNT_EN (stall cycle counter).
package matmul_stream_pkg;

   localparam int DEF_M      = 4;
   localparam int DEF_N      = 4;
   localparam int DEF_K      = 4;
   localparam int DEF_DATA_W = 32;
   localparam int STALL_W    = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Index width for a range of n values; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Load address width: wide enough for the larger of the two banks.
   function automatic int addr_w(input int m, input int n, input int k);
      return idx_w((m * k > k * n) ? m * k : k * n);
   endfunction

endpackage

// File: rtl/matmul_operand_streamer_if.sv
// Operand-pair stream from the streamer (master) to the matmul core (slave).
interface matmul_operand_streamer_if #(
   parameter int DATA_W = matmul_stream_pkg::DEF_DATA_W
);
   logic              valid_out;
   logic              ready_in;
   logic [DATA_W-1:0] data_a;
   logic [DATA_W-1:0] data_b;
   logic              k_last;
   logic              out_last;

   modport master (output valid_out, data_a, data_b, k_last, out_last, input ready_in);
   modport slave  (input valid_out, data_a, data_b, k_last, out_last, output ready_in);
endinterface

// File: rtl/matmul_operand_bank.sv
// Operand register file: synchronous write with range check, combinational read.
module matmul_operand_bank
   import matmul_stream_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [ADDR_W-1:0]         waddr,
   input  logic [DATA_W-1:0]         wdata,
   input  logic [idx_w(DEPTH)-1:0]   raddr,
   output logic [DATA_W-1:0]         rdata
);
   localparam int IDX_W = idx_w(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              in_range;

   // Extra MSB keeps the compare correct when DEPTH equals 2**ADDR_W.
   assign in_range = ({1'b0, waddr} < (ADDR_W + 1)'(DEPTH));

   // Store an element; addresses beyond this bank are dropped.
   // NOTE: storage has no reset so operand contents survive rst.
   always_ff @(posedge clk) begin
      if (we && in_range) mem[waddr[IDX_W-1:0]] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/matmul_operand_streamer.sv
// Streams A[i][k] / B[k][j] pairs to a matmul core, i outer, j middle, k inner.
// Optional feature macro: MATMUL_STREAM_STALL_CNT_EN adds the stall_cycles output.
module matmul_operand_streamer
   import matmul_stream_pkg::*;
#(
   parameter int M      = DEF_M,
   parameter int N      = DEF_N,
   parameter int K      = DEF_K,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en,
   input  logic                        wr_sel,
   input  logic [addr_w(M, N, K)-1:0]  wr_addr,
   input  logic [DATA_W-1:0]           wr_data,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   matmul_operand_streamer_if.master   s
`ifdef MATMUL_STREAM_STALL_CNT_EN
   , output logic [STALL_W-1:0]        stall_cycles
`endif
);
   localparam int ADDR_W  = addr_w(M, N, K);
   localparam int I_W     = idx_w(M);
   localparam int J_W     = idx_w(N);
   localparam int K_W     = idx_w(K);
   localparam int A_IDX_W = idx_w(M * K);
   localparam int B_IDX_W = idx_w(K * N);

   localparam logic [I_W-1:0] I_LAST = I_W'(M - 1);
   localparam logic [J_W-1:0] J_LAST = J_W'(N - 1);
   localparam logic [K_W-1:0] K_LAST = K_W'(K - 1);

   state_t              state;
   logic                valid_q;
   logic [I_W-1:0]      i_idx;
   logic [J_W-1:0]      j_idx;
   logic [K_W-1:0]      k_idx;
   logic                hs;
   logic                i_at_last, j_at_last, k_at_last, beat_last;
   logic [A_IDX_W-1:0]  a_raddr;
   logic [B_IDX_W-1:0]  b_raddr;
   logic [DATA_W-1:0]   a_rdata, b_rdata;

   assign hs        = valid_q & s.ready_in;
   assign i_at_last = (i_idx == I_LAST);
   assign j_at_last = (j_idx == J_LAST);
   assign k_at_last = (k_idx == K_LAST);
   assign beat_last = i_at_last & j_at_last & k_at_last;

   // Row-major element addresses of A[i][k] and B[k][j].
   assign a_raddr = A_IDX_W'(int'(i_idx) * K + int'(k_idx));
   assign b_raddr = B_IDX_W'(int'(k_idx) * N + int'(j_idx));

   // Banks are frozen while busy, so a held beat reads the same data every cycle.
   matmul_operand_bank #(.DEPTH(M * K), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank_a (
      .clk   (clk),
      .we    (wr_en & ~busy & ~wr_sel),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (a_raddr),
      .rdata (a_rdata)
   );

   matmul_operand_bank #(.DEPTH(K * N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank_b (
      .clk   (clk),
      .we    (wr_en & ~busy & wr_sel),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (b_raddr),
      .rdata (b_rdata)
   );

   // Run control: sequence the indices on handshakes and drive busy/done/valid.
   // NOTE: every register here uses <= so all of them see pre-edge values together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         valid_q <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         i_idx   <= '0;
         j_idx   <= '0;
         k_idx   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_STREAM;
                  valid_q <= 1'b1;
                  busy    <= 1'b1;
                  i_idx   <= '0;
                  j_idx   <= '0;
                  k_idx   <= '0;
               end
            end
            ST_STREAM: begin
               if (hs) begin
                  if (beat_last) begin
                     state   <= ST_DONE;
                     valid_q <= 1'b0;
                     done    <= 1'b1;
                  end else if (k_at_last) begin
                     k_idx <= '0;
                     if (j_at_last) begin
                        j_idx <= '0;
                        i_idx <= i_idx + 1'b1;
                     end else begin
                        j_idx <= j_idx + 1'b1;
                     end
                  end else begin
                     k_idx <= k_idx + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state   <= ST_IDLE;
               valid_q <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

   // Beat fields decode from registered state only; they read zero outside a beat.
   assign s.valid_out = valid_q;
   assign s.data_a    = valid_q ? a_rdata : '0;
   assign s.data_b    = valid_q ? b_rdata : '0;
   assign s.k_last    = valid_q & k_at_last;
   assign s.out_last  = valid_q & beat_last;

`ifdef MATMUL_STREAM_STALL_CNT_EN
   logic [STALL_W-1:0] stall_q;

   // Count cycles a beat waits on the core; saturates, restarts with each run.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (state == ST_IDLE && start) begin
         stall_q <= '0;
      end else if (state == ST_STREAM && valid_q && !s.ready_in && stall_q != '1) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/matmul_operand_streamer.md
MATMUL_OPERAND_STREAMER -- requirements
Module: matmul_operand_streamer

Interface
REQ-001 SHALL have parameter M, default 4: rows of A and of C.
REQ-002 SHALL have parameter N, default 4: columns of B and of C.
REQ-003 SHALL have parameter K, default 4: the small inner dimension.
REQ-004 SHALL have parameter DATA_W, default 32: operand width.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port wr_en, input, 1: operand load strobe.
REQ-008 SHALL have port wr_sel, input, 1: load target, 0 = A bank, 1 = B bank.
REQ-009 SHALL have port wr_addr, input, clog2(max(M*K,K*N)): row-major element index.
REQ-010 SHALL have port wr_data, input, DATA_W: element value.
REQ-011 SHALL have port start, input, 1: begin streaming.
REQ-012 SHALL have port busy, output, 1: high while streaming.
REQ-013 SHALL have port done, output, 1: one-cycle pulse after the final beat.
REQ-014 SHALL have port valid_out, output, 1: operand pair valid to the matmul core.
REQ-015 SHALL have port ready_in, input, 1: matmul core accepts the pair.
REQ-016 SHALL have port data_a, output, DATA_W: A[i][k].
REQ-017 SHALL have port data_b, output, DATA_W: B[k][j].
REQ-018 SHALL have port k_last, output, 1: beat carries k = K-1.
REQ-019 SHALL have port out_last, output, 1: beat carries i = M-1, j = N-1, k = K-1.

Function
REQ-020 SHALL run an FSM with states IDLE, STREAM and DONE: IDLE->STREAM on start; STREAM->DONE on handshake of the out_last beat; DONE->IDLE unconditionally one cycle later.
REQ-021 SHALL define a handshake as a rising edge where valid_out && ready_in is high; only handshakes advance the indices.
REQ-022 SHALL emit beats in order i outer, j middle, k inner, giving exactly M*N*K beats per run.
REQ-023 SHALL hold valid_out high in STREAM only, with the first beat (i=j=k=0) visible in the cycle after start is sampled.
REQ-024 SHALL hold data_a, data_b, k_last and out_last stable while valid_out && !ready_in.
REQ-025 SHALL accept ready_in changing in any cycle and SHALL NOT let valid_out depend combinationally on ready_in.
REQ-026 SHALL drive busy high in STREAM and DONE, and drive done high only in DONE.
REQ-027 SHALL ignore start while busy.
REQ-028 SHALL ignore wr_en while busy, leaving the banks unchanged.
REQ-029 SHALL ignore writes whose wr_addr is out of range for the selected bank (>= M*K for A, >= K*N for B).
REQ-030 SHALL take effect on the next rising edge for any write made in IDLE; a start in the same cycle as a write SHALL stream the newly written value.
REQ-031 SHALL wrap k to 0 after K-1 and j to 0 after N-1, with no idle bubble between beats when ready_in is held high.
REQ-032 SHALL allow a new start in the cycle after DONE.

Reset
REQ-033 SHALL, on rst, go to IDLE, clear all indices, and drive busy, done, valid_out, k_last and out_last to 0 and data_a and data_b to 0.
REQ-034 SHALL abort a run in progress on rst, emitting no done pulse and no further beats.
REQ-035 SHALL NOT clear bank contents on rst.

Configuration
REQ-036 SHALL, when MATMUL_STREAM_STALL_CNT_EN is defined, provide output stall_cycles (16 bits) that counts cycles in STREAM with valid_out && !ready_in, saturates at 16'hFFFF, clears on an accepted start and clears on rst.
REQ-037 SHALL, when MATMUL_STREAM_STALL_CNT_EN is undefined, have no stall_cycles port and no counter logic.

Structure
REQ-038 SHALL place the FSM state enum, the default M/N/K/DATA_W values and the index-width helper constants in the shared package matmul_stream_pkg.
REQ-039 SHALL implement each operand bank as sub-module matmul_operand_bank (a register file with synchronous write and combinational read), instantiated twice, once for A and once for B.

Verification
REQ-040 SHALL cover: A = identity 4x4, B[k][j] = 10*k+j, start, ready_in held high -> 64 beats on consecutive cycles; beat 5 gives data_a=0, data_b=11; k_last on beats 3, 7, ..., 63; out_last only on beat 63; done one cycle later.
REQ-041 SHALL cover: ready_in low for 3 cycles at beat 10 -> data_a, data_b and valid_out unchanged for those cycles, beat 11 follows the handshake, and stall_cycles = 3 with the macro defined.
REQ-042 SHALL cover: start pulsed again at beat 20, plus a write of 0xDEAD to A[0] mid-run -> no restart, A[0] unchanged, still 64 beats total.
REQ-043 SHALL cover: rst asserted at beat 30 -> valid_out=0 and busy=0 the next cycle, no done pulse, and a fresh start replays from i=j=k=0 with the same bank data.
REQ-044 SHALL cover: a write with wr_addr=16, wr_sel=0 at M=K=4 -> A bank unchanged; a write and start in the same cycle -> the first beat shows the new value.
